// File: rtl/seq_det_pkg.sv
// Shared types and constants for the programmable sequence detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Reset pattern 11011, bit 0 is the most recently received bit.
    localparam logic [7:0] DefPat = 8'b00011011;
    localparam int unsigned DefLen = 5;

    // Effective pattern length: 0 means 1, anything above the width clamps to the width.
    function automatic int unsigned eff_len(input int unsigned len, input int unsigned pw);
        if (len == 0) begin
            return 1;
        end else if (len > pw) begin
            return pw;
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/seq_match_core.sv
// Bit history shift register with a masked compare against the programmed pattern.
module seq_match_core
    import seq_det_pkg::*;
#(
    parameter int unsigned PW = 8,
    parameter int unsigned LW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [PW-1:0] pattern_i,
    input  logic [LW-1:0] len_i,
    input  logic          n_i,
    input  logic          n_valid_i,
    input  logic          clear_i,
    input  logic          nonov_clear_i,
    output logic          match_o
);

    logic [PW-1:0] hist_q, hist_d;
    logic [LW-1:0] seen_q, seen_d;
    logic [PW-1:0] window;
    logic [PW-1:0] mask;
    logic          hit;
    logic          enough;

    // Raw match: last L bits including the incoming one equal the pattern, and enough fresh bits.
    always_comb begin
        window = {hist_q[PW-2:0], n_i};
        mask   = '0;
        for (int unsigned i = 0; i < PW; i++) begin
            mask[i] = (i < 32'(len_i));
        end
        hit     = (((window ^ pattern_i) & mask) == '0);
        enough  = (({1'b0, seen_q} + {{LW{1'b0}}, 1'b1}) >= {1'b0, len_i});
        match_o = n_valid_i && hit && enough;
    end

    // History and fresh-bit counter; a non-overlapping match restarts the fresh count.
    always_comb begin
        hist_d = hist_q;
        seen_d = seen_q;
        if (clear_i) begin
            hist_d = '0;
            seen_d = '0;
        end else if (n_valid_i) begin
            hist_d = window;
            if (nonov_clear_i) begin
                seen_d = '0;
            end else if (seen_q < LW'(PW)) begin
                seen_d = seen_q + LW'(1);
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            seen_q <= '0;
        end else begin
            hist_q <= hist_d;
            seen_q <= seen_d;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller for the programmable serial sequence detector: config, FSM, match counter.
module seq_detect_ctrl
    import seq_det_pkg::*;
#(
    parameter int unsigned   PW      = 8,
    parameter int unsigned   LW      = 4,
    parameter int unsigned   CW      = 8,
    parameter logic [PW-1:0] DEF_PAT = PW'(DefPat),
    parameter int unsigned   DEF_LEN = DefLen
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [PW-1:0] cfg_pattern,
    input  logic [LW-1:0] cfg_len,
    input  logic          cfg_overlap,
    input  logic [CW-1:0] cfg_target,
    input  logic          start,
    input  logic          abort,
    input  logic          n,
    input  logic          n_valid,
    output logic          d,
    output logic [CW-1:0] match_count,
    output logic          busy,
    output logic          done
);

    state_e        state_q, state_d;
    logic [PW-1:0] pat_q, pat_d;
    logic [LW-1:0] len_q, len_d;
    logic          ov_q, ov_d;
    logic [CW-1:0] tgt_q, tgt_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [LW-1:0] len_eff;
    logic          n_valid_run;
    logic          match_raw;
    logic          clear;
    logic          nonov_clear;
    logic          last_match;

    assign len_eff     = LW'(eff_len(32'(len_q), PW));
    assign n_valid_run = n_valid && (state_q == StRun);
    assign last_match  = (tgt_q != '0) &&
                         (({1'b0, cnt_q} + {{CW{1'b0}}, 1'b1}) == {1'b0, tgt_q});

    seq_match_core #(
        .PW (PW),
        .LW (LW)
    ) u_core (
        .clk           (clk),
        .rst           (rst),
        .pattern_i     (pat_q),
        .len_i         (len_eff),
        .n_i           (n),
        .n_valid_i     (n_valid_run),
        .clear_i       (clear),
        .nonov_clear_i (nonov_clear),
        .match_o       (match_raw)
    );

    // Mealy pulse: the core only sees valid bits while running.
    assign d           = match_raw;
    assign match_count = cnt_q;

    // Next-state, config capture and counter; abort wins over start and over a same-cycle match.
    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        len_d       = len_q;
        ov_d        = ov_q;
        tgt_d       = tgt_q;
        cnt_d       = cnt_q;
        clear       = 1'b0;
        nonov_clear = 1'b0;
        cfg_ready   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                cfg_ready = 1'b1;
                done      = (state_q == StDone);
                if (cfg_valid) begin
                    pat_d = cfg_pattern;
                    len_d = cfg_len;
                    ov_d  = cfg_overlap;
                    tgt_d = cfg_target;
                end
                if (abort) begin
                    state_d = StIdle;
                end else if (start) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    clear   = 1'b1;
                end
            end
            StRun: begin
                busy = 1'b1;
                if (abort) begin
                    state_d = StIdle;
                end else if (match_raw) begin
                    if (cnt_q != {CW{1'b1}}) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    nonov_clear = !ov_q;
                    if (last_match) begin
                        state_d = StDone;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, config and counter registers; reset restores the default config.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pat_q   <= DEF_PAT;
            len_q   <= LW'(DEF_LEN);
            ov_q    <= 1'b1;
            tgt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ov_q    <= ov_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl with a queue-based reference model checked every cycle.
module tb_seq_detect_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, cfg_valid, cfg_overlap, start, abort, n, n_valid;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic [7:0] cfg_target;
    logic       cfg_ready, d, busy, done;
    logic [7:0] match_count;
    logic       s_cfg_ready, s_d, s_busy, s_done;
    logic [1:0] s_match_count, s_target;

    assign s_target = cfg_target[1:0];

    seq_detect_ctrl u_dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_target  (cfg_target),
        .start       (start),
        .abort       (abort),
        .n           (n),
        .n_valid     (n_valid),
        .d           (d),
        .match_count (match_count),
        .busy        (busy),
        .done        (done)
    );

    // Narrow-counter instance to observe saturation.
    seq_detect_ctrl #(
        .CW (2)
    ) u_sat (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (s_cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_target  (s_target),
        .start       (start),
        .abort       (abort),
        .n           (n),
        .n_valid     (n_valid),
        .d           (s_d),
        .match_count (s_match_count),
        .busy        (s_busy),
        .done        (s_done)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: 0 idle, 1 running, 2 done; bits holds the fresh bits, oldest first.
    int         m_st;
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ov;
    int         m_tgt;
    int         m_cnt;
    bit         m_bits[$];
    logic       last_d;
    logic [15:0] dv;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit model_d();
        int L;
        bit b;
        if (m_st != 1 || n_valid !== 1'b1) return 1'b0;
        L = (m_len == 0) ? 1 : ((m_len > 8) ? 8 : m_len);
        if (m_bits.size() + 1 < L) return 1'b0;
        for (int i = 0; i < L; i++) begin
            b = (i == 0) ? n : m_bits[m_bits.size() - i];
            if (b != m_pat[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_step();
        bit hit;
        if (rst) begin
            m_st = 0; m_pat = 8'b00011011; m_len = 5; m_ov = 1; m_tgt = 0; m_cnt = 0;
            m_bits.delete();
            return;
        end
        if (m_st != 1) begin
            if (cfg_valid) begin
                m_pat = cfg_pattern; m_len = int'(cfg_len); m_ov = cfg_overlap;
                m_tgt = int'(cfg_target);
            end
            if (abort) m_st = 0;
            else if (start) begin
                m_st = 1; m_cnt = 0; m_bits.delete();
            end
        end else if (abort) begin
            m_st = 0;
        end else if (n_valid) begin
            hit = model_d();
            m_bits.push_back(n);
            if (m_bits.size() > 8) void'(m_bits.pop_front());
            if (hit) begin
                if (m_cnt < 255) m_cnt++;
                if (!m_ov) m_bits.delete();
                if (m_tgt != 0 && m_cnt == m_tgt) m_st = 2;
            end
        end
    endtask

    // One clock: compare both instances against the model mid-cycle, then advance the model.
    task automatic cycle();
        @(negedge clk);
        check("d", 32'(d), 32'(model_d()));
        check("busy", 32'(busy), 32'(m_st == 1));
        check("done", 32'(done), 32'(m_st == 2));
        check("cfg_ready", 32'(cfg_ready), 32'(m_st != 1));
        check("match_count", 32'(match_count), 32'((m_cnt > 255) ? 255 : m_cnt));
        check("sat_d", 32'(s_d), 32'(model_d()));
        check("sat_done", 32'(s_done), 32'(m_st == 2));
        check("sat_count", 32'(s_match_count), 32'((m_cnt > 3) ? 3 : m_cnt));
        last_d = d;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic configure(input logic [7:0] pat, input logic [3:0] len, input logic ov,
                             input logic [7:0] tgt, input logic with_start);
        cfg_valid = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ov;
        cfg_target = tgt; start = with_start;
        cycle();
        cfg_valid = 1'b0; start = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        cycle();
        abort = 1'b0;
    endtask

    // Send cnt bits, first bit is v[cnt-1]; out[k] records d for bit k+1.
    task automatic send(input logic [15:0] v, input int cnt, input int gap,
                        output logic [15:0] out);
        out = '0;
        for (int k = 0; k < cnt; k++) begin
            n = v[cnt-1-k]; n_valid = 1'b1;
            cycle();
            out[k] = last_d;
            n_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                n = 1'($urandom_range(1));
                cycle();
            end
        end
        n_valid = 1'b0; n = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_overlap = 1'b0; start = 1'b0; abort = 1'b0;
        n = 1'b0; n_valid = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_target = '0;
        @(posedge clk);
        model_step();
        #1;
        rst = 1'b0;
        check("reset_cfg_ready", 32'(cfg_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_count", 32'(match_count), 32'd0);

        // Default overlapping 11011.
        do_start();
        send(16'b11011011, 8, 0, dv);
        check("t1_d_positions", 32'(dv), 32'h0090);
        check("t1_count", 32'(match_count), 32'd2);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_done", 32'(done), 32'd0);
        do_abort();

        // Non-overlapping, config and start in the same cycle.
        configure(8'b00011011, 4'd5, 1'b0, 8'd0, 1'b1);
        send(16'b11011011, 8, 0, dv);
        check("t2_d_positions", 32'(dv), 32'h0010);
        check("t2_count", 32'(match_count), 32'd1);
        do_abort();

        // Target of two on 101.
        configure(8'b00000101, 4'd3, 1'b1, 8'd2, 1'b1);
        send(16'b1010101, 7, 0, dv);
        check("t3_d_positions", 32'(dv), 32'h0014);
        check("t3_done", 32'(done), 32'd1);
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_count", 32'(match_count), 32'd2);

        // Same run with invalid gaps, restarted from DONE.
        do_start();
        send(16'b1010101, 7, 2, dv);
        check("t4_d_positions", 32'(dv), 32'h0014);
        check("t4_done", 32'(done), 32'd1);

        // Abort on a completing match.
        configure(8'b00011011, 4'd5, 1'b1, 8'd0, 1'b1);
        send(16'b1101101, 7, 0, dv);
        check("t5_d_positions", 32'(dv), 32'h0010);
        n = 1'b1; n_valid = 1'b1; abort = 1'b1;
        cycle();
        abort = 1'b0; n_valid = 1'b0;
        check("t5_abort_d", 32'(last_d), 32'd1);
        check("t5_count_held", 32'(match_count), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);

        // Length 0 acts as 1; narrow counter saturates with unlimited target.
        configure(8'h01, 4'd0, 1'b1, 8'd0, 1'b1);
        send(16'b101111, 6, 0, dv);
        check("t6_len0_d", 32'(dv), 32'h003D);
        check("t6_count", 32'(match_count), 32'd5);
        check("t6_sat_count", 32'(s_match_count), 32'd3);
        check("t6_sat_done", 32'(s_done), 32'd0);
        do_abort();

        // Length 15 clamps to 8, with a start request ignored mid-run.
        configure(8'hA5, 4'd15, 1'b1, 8'd0, 1'b1);
        start = 1'b1;
        send(16'b10100101, 8, 0, dv);
        start = 1'b0;
        check("t6_len15_d", 32'(dv), 32'h0080);
        check("t6_len15_count", 32'(match_count), 32'd1);

        // Reset mid-run restores defaults.
        send(16'b110, 3, 0, dv);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_count", 32'(match_count), 32'd0);
        check("t6_rst_ready", 32'(cfg_ready), 32'd1);
        check("t6_rst_d", 32'(d), 32'd0);
        do_start();
        send(16'b11011, 5, 0, dv);
        check("t6_defpat_d", 32'(dv), 32'h0010);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Programmable serial sequence-detector controller. It configures the match pattern, length, overlap mode and a target match count, then sequences one detection run over the serial input n. It produces the Mealy match pulse d, counts matches, and stops with done when the target is reached. It sits between a config/control master and the serial bit source, replacing the fixed-pattern overlapping and non-overlapping detectors.

Parameters:
PW, 8, maximum pattern width in bits.
LW, 4, width of cfg_len; must hold PW.
CW, 8, width of the match counter and cfg_target.
DEF_PAT, 8'b00011011, reset pattern (11011, LSB = last bit received).
DEF_LEN, 5, reset pattern length.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous active-high reset.
cfg_valid  in  1  config offer.
cfg_ready  out  1  config accepted when cfg_valid && cfg_ready.
cfg_pattern  in  PW  pattern; bit 0 = most recent bit.
cfg_len  in  LW  pattern length.
cfg_overlap  in  1  1 = overlapping, 0 = non-overlapping.
cfg_target  in  CW  matches to finish; 0 = unlimited.
start  in  1  begin a run.
abort  in  1  end a run immediately.
n  in  1  serial data bit.
n_valid  in  1  n is sampled this cycle.
d  out  1  Mealy match pulse (combinational).
match_count  out  CW  matches in the current run.
busy  out  1  run in progress.
done  out  1  target reached; held.

Behaviour:
- Clock is clk; reset is synchronous, active-high, named rst.
- Reset values: state IDLE; pattern=DEF_PAT, len=DEF_LEN, overlap=1, target=0; hist=0, seen=0, match_count=0; busy=0, done=0, d=0, cfg_ready=1.
- States: IDLE, RUN, DONE.
  - IDLE: cfg_ready=1. A config handshake loads all cfg_* fields on the next edge. start moves to RUN and clears hist, seen and match_count. If cfg handshake and start occur together, the new config applies to the run.
  - RUN: cfg_ready=0, busy=1. On n_valid, hist <= {hist[PW-2:0], n} and seen <= min(seen+1, PW).
  - DONE: done=1, busy=0, cfg_ready=1. Config may load. start re-enters RUN with cleared counters and drops done.
- Length rule: effective len L = 1 if cfg_len=0; PW if cfg_len>PW; otherwise cfg_len.
- Match (Mealy): d = (state==RUN) && n_valid && ({hist,n}[L-1:0] == pattern[L-1:0]) && (seen+1 >= L).
  - d is asserted in the same cycle as the completing bit. There is no registered latency.
- On a match edge:
  - match_count increments, saturating at 2^CW-1.
  - Non-overlapping mode: seen <= 0, so the next match needs L fresh bits.
  - Overlapping mode: seen updates normally.
- Completion: if target != 0 and match_count+1 == target on a match, go to DONE on that edge. d still pulses for that bit.
- n_valid=0: no shift, no match, d=0.
- abort: from RUN or DONE, go to IDLE next edge; done=0, match_count is held. abort has priority over start and over a simultaneous match; d is still combinationally 1 in that cycle if the match term holds, but the count is not incremented.
- start while in RUN is ignored.
- rst mid-run returns everything to reset values, including config, on that edge.

Decomposition:
- Package seq_det_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - DEF_PAT and DEF_LEN constants;
  - a function for the effective-length clamp.
- One sub-module, seq_match_core: hist/seen shift register plus the masked compare producing the raw match. Inputs: pattern, L, n, n_valid, clear, nonov_clear.
- The controller FSM, config registers and counter stay in seq_detect_ctrl.

Test Plan:
1. Reset defaults, start, stream 1,1,0,1,1,0,1,1 (n_valid=1 every cycle) -> d=1 on bits 5 and 8 only; match_count=2; busy=1, done=0.
2. Load overlap=0, len=5, pattern=11011, target=0, same stream -> d=1 on bit 5 only; match_count=1.
3. Config len=3, pattern=101, overlap=1, target=2, stream 1,0,1,0,1,0,1 -> d on bits 3 and 5; DONE after bit 5; done=1, busy=0; bit 7 gives no d, count stays 2.
4. Same stream with n_valid=0 gaps between bits -> identical d positions counted in valid bits; d=0 in every gap cycle.
5. abort asserted in the same cycle as a completing match -> d=1 that cycle; count not incremented; state IDLE next edge; done=0.
6. Boundaries:
   - cfg_len=0, pattern bit0=1, stream 1,0,1 -> d on bits 1 and 3.
   - cfg_len=15 clamps to 8.
   - target=0 with CW=2 and 5 matches -> count saturates at 3, no DONE.
   - rst mid-RUN -> all outputs back to reset values; DEF_PAT restored.
